ysyx_22051013_clint: RTL and testbench
======================================

Name: ysyx_22051013_clint

Overview:
Core-local interruptor; the producer side of the machine timer/software interrupt lines consumed by the CSR unit. Holds the mtime counter, the mtimecmp compare register and the msip bit. These are exposed as memory-mapped 64-bit registers on a simple valid/ready request/response bus from the LSU. Drives a registered level time_interrupt (mtime >= mtimecmp) and a soft_interrupt level (msip).

Parameters:
BASE_ADDR, 64'h0000_0000_0200_0000, base of the CLINT window.
TICK_DIV, 1, core clocks per mtime increment (1..65535); 1 means increment every cycle.

Ports:
clk  in  1  core clock
rst  in  1  synchronous reset, active-high
req_valid  in  1  LSU request valid
req_ready  out  1  CLINT can accept a request
req_wen  in  1  1 = write, 0 = read
req_addr  in  64  byte address
req_wdata  in  64  write data
req_wmask  in  8  byte enables for writes
resp_valid  out  1  response valid
resp_ready  in  1  LSU accepts the response
resp_rdata  out  64  read data; 0 for writes
resp_err  out  1  address not mapped
time_interrupt  out  1  level, to CSR mip.MTIP sampling
soft_interrupt  out  1  level, msip[0]

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst); all state updates on posedge clk.
- Register map, offsets from BASE_ADDR, decoded on addr[15:3] with addr[2:0] ignored:
  - 0x0000 msip: bit 0 only; other bits read 0.
  - 0x4000 mtimecmp.
  - 0xBFF8 mtime.
  - Any other address in or outside the window is unmapped.
- Reset values:
  - mtime = 0, mtimecmp = 64'hFFFF_FFFF_FFFF_FFFF, msip = 0, prescaler = 0.
  - state = IDLE, req_ready = 1, resp_valid = 0, resp_rdata = 0, resp_err = 0.
  - time_interrupt = 0, soft_interrupt = 0.
- Bus FSM: IDLE, RESP.
  - IDLE: req_ready = 1. On req_valid, the handshake fires. Perform the access, latch resp_rdata/resp_err, go to RESP.
  - RESP: req_ready = 0, resp_valid = 1. rdata and err are held stable until resp_ready; then return to IDLE.
  - Max throughput is one request per 2 cycles. No combinational path from req_* to resp_*.
- Reads return the value before any same-cycle tick (pre-increment mtime).
- Writes merge bytes: reg[8i+7:8i] <= wdata[8i+7:8i] where wmask[i]=1.
  - msip uses wmask[0], wdata[0] only.
  - wmask = 0 is a no-op with a normal response.
- Unmapped access: no state change, rdata = 0, err = 1, still completes the handshake.
- Prescaler counts 0..TICK_DIV-1. When it reaches TICK_DIV-1 it wraps to 0 and mtime increments by 1.
  - mtime wraps 64'hFFFF_FFFF_FFFF_FFFF -> 0 silently.
  - mtime counts regardless of bus state.
- Same cycle mtime write and tick: the write wins, with no increment that cycle; the prescaler clears to 0.
- Writes to mtimecmp/mtime take effect on the next cycle.
- time_interrupt is a register: time_interrupt <= (mtime >= mtimecmp), unsigned, using current-cycle register values. Asserts 1 cycle after the condition holds and deasserts 1 cycle after it stops holding.
  - After writing mtimecmp to a larger value, the line drops within 2 cycles of the write handshake.
- soft_interrupt = msip register bit, direct.
- rst mid-transaction: the FSM returns to IDLE, the pending response is dropped, all registers take reset values.

Decomposition:
- Shared package/define file: CLINT offset constants (MSIP 16'h0000, MTIMECMP 16'h4000, MTIME 16'hBFF8), the FSM state encoding, and a function for the byte-mask merge.
- One sub-module: ysyx_22051013_clint_timer, containing the prescaler, mtime, mtimecmp, the compare register and the write/tick priority. The top level keeps the decode, the bus FSM and msip.

Test Plan:
- Reset, then idle 10 cycles with TICK_DIV=1 -> read mtime returns 10 ± handshake offset (exact value checked against cycle count); time_interrupt = 0, soft_interrupt = 0.
- Write mtimecmp = 20 at mtime ≈ 5 -> time_interrupt rises exactly 1 cycle after mtime == 20. Then write mtimecmp = 64'hFFFF_FFFF_FFFF_FFFF -> it falls within 2 cycles.
- Write mtime = 64'hFFFF_FFFF_FFFF_FFFE with TICK_DIV=1 -> reads show wrap to 0 after 2 ticks. Write a value on the same cycle as a tick -> readback equals the written value with no +1.
- Write msip with wdata = 1, wmask = 8'h01 -> soft_interrupt = 1. Write wdata = 0, wmask = 8'h00 -> remains 1. Then wmask = 8'h01 -> 0.
- Byte mask: mtimecmp = 0, write wdata = 64'h1122_3344_5566_7788 with wmask = 8'h0F -> read 64'h0000_0000_5566_7788. Read of BASE+0x1000 -> rdata = 0, resp_err = 1.
- Back-pressure: hold resp_ready = 0 for 5 cycles -> resp_valid and resp_rdata are stable and req_ready = 0. Assert rst during RESP -> next cycle resp_valid = 0, req_ready = 1, mtime = 0.

Source files
------------

// File: rtl/ysyx_22051013_clint_pkg.sv
// Shared definitions for the core-local interruptor: register offsets inside
// the CLINT window, bus FSM state encoding and the byte-lane merge helper.
package ysyx_22051013_clint_pkg;

    // Offsets from BASE_ADDR (8-byte aligned, low three address bits ignored)
    localparam logic [15:0] CLINT_MSIP     = 16'h0000;
    localparam logic [15:0] CLINT_MTIMECMP = 16'h4000;
    localparam logic [15:0] CLINT_MTIME    = 16'hBFF8;

    // Bus FSM: accept a request in IDLE, present the response in RESP
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } clint_state_e;

    // Replace each byte of old_v whose enable bit is set with the write byte
    function automatic logic [63:0] merge_bytes(input logic [63:0] old_v,
                                                input logic [63:0] wdata,
                                                input logic [7:0]  wmask);
        logic [63:0] res;
        res = old_v;
        for (int i = 0; i < 8; i++) begin
            if (wmask[i]) begin
                res[8*i +: 8] = wdata[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/ysyx_22051013_clint_timer.sv
// Machine timer: prescaler, mtime counter, mtimecmp register and the
// registered mtime >= mtimecmp comparison that drives the timer interrupt.
// A software write to mtime overrides the increment of the same cycle.
module ysyx_22051013_clint_timer
    import ysyx_22051013_clint_pkg::*;
#(
    parameter int unsigned TICK_DIV = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmp_we_i,
    input  logic        time_we_i,
    input  logic [63:0] wdata_i,
    input  logic [7:0]  wmask_i,
    output logic [63:0] mtime_o,
    output logic [63:0] mtimecmp_o,
    output logic        time_irq_o
);

    // Last prescaler value before a tick; TICK_DIV = 1 ticks every cycle
    localparam logic [15:0] DIV_LAST = 16'(TICK_DIV - 1);

    logic [15:0] presc_q, presc_d;
    logic [63:0] mtime_q, mtime_d;
    logic [63:0] cmp_q,   cmp_d;
    logic        irq_q;
    logic        tick;

    assign tick = (presc_q >= DIV_LAST);

    // Next-state: prescaler wrap/tick, mtime write-over-tick priority, mtimecmp merge
    always_comb begin
        presc_d = presc_q + 16'd1;
        mtime_d = mtime_q;
        cmp_d   = cmp_q;
        if (tick) begin
            presc_d = 16'd0;
            mtime_d = mtime_q + 64'd1;
        end
        if (time_we_i) begin
            mtime_d = merge_bytes(mtime_q, wdata_i, wmask_i);
        end
        if (cmp_we_i) begin
            cmp_d = merge_bytes(cmp_q, wdata_i, wmask_i);
        end
    end

    // Timer state registers; the interrupt samples the current register values
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q <= 16'd0;
            mtime_q <= 64'd0;
            cmp_q   <= 64'hFFFF_FFFF_FFFF_FFFF;
            irq_q   <= 1'b0;
        end else begin
            presc_q <= presc_d;
            mtime_q <= mtime_d;
            cmp_q   <= cmp_d;
            irq_q   <= (mtime_q >= cmp_q);
        end
    end

    assign mtime_o    = mtime_q;
    assign mtimecmp_o = cmp_q;
    assign time_irq_o = irq_q;

endmodule

// File: rtl/ysyx_22051013_clint.sv
// Core-local interruptor top: address decode, two-state request/response bus
// FSM and the msip bit. The timer datapath lives in ysyx_22051013_clint_timer.
// Responses are fully registered, so nothing on req_* reaches resp_* in the
// same cycle.
module ysyx_22051013_clint
    import ysyx_22051013_clint_pkg::*;
#(
    parameter logic [63:0] BASE_ADDR = 64'h0000_0000_0200_0000,
    parameter int unsigned TICK_DIV  = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    input  logic [7:0]  req_wmask,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_rdata,
    output logic        resp_err,
    output logic        time_interrupt,
    output logic        soft_interrupt
);

    clint_state_e state_q, state_d;
    logic [63:0]  rdata_q, rdata_d;
    logic         err_q,   err_d;
    logic         msip_q,  msip_d;

    logic [63:0]  mtime, mtimecmp;
    logic         time_irq;
    logic         cmp_we, time_we;

    logic         in_window;
    logic [15:0]  offset;
    logic         sel_msip, sel_cmp, sel_time, mapped;
    logic         addr_lo_unused;

    // Byte offset within the 64 KiB window; the byte-within-word bits are don't-care
    assign in_window      = (req_addr[63:16] == BASE_ADDR[63:16]);
    assign offset         = {req_addr[15:3], 3'b000};
    assign addr_lo_unused = ^req_addr[2:0];

    assign sel_msip = in_window && (offset == CLINT_MSIP);
    assign sel_cmp  = in_window && (offset == CLINT_MTIMECMP);
    assign sel_time = in_window && (offset == CLINT_MTIME);
    assign mapped   = sel_msip || sel_cmp || sel_time;

    // Bus FSM next-state plus the access performed at the request handshake
    always_comb begin
        state_d = state_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        msip_d  = msip_q;
        cmp_we  = 1'b0;
        time_we = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    state_d = ST_RESP;
                    err_d   = !mapped;
                    rdata_d = 64'd0;
                    if (mapped && req_wen) begin
                        if (sel_msip && req_wmask[0]) begin
                            msip_d = req_wdata[0];
                        end
                        // An all-zero mask must not block the tick on mtime
                        cmp_we  = sel_cmp  && (req_wmask != 8'h00);
                        time_we = sel_time && (req_wmask != 8'h00);
                    end else if (mapped) begin
                        // Reads see register values before this edge's tick
                        if (sel_msip) begin
                            rdata_d = {63'd0, msip_q};
                        end else if (sel_cmp) begin
                            rdata_d = mtimecmp;
                        end else begin
                            rdata_d = mtime;
                        end
                    end
                end
            end
            ST_RESP: begin
                if (resp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM state, latched response and msip; reset drops any pending response
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            rdata_q <= 64'd0;
            err_q   <= 1'b0;
            msip_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            msip_q  <= msip_d;
        end
    end

    ysyx_22051013_clint_timer #(
        .TICK_DIV(TICK_DIV)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .cmp_we_i  (cmp_we),
        .time_we_i (time_we),
        .wdata_i   (req_wdata),
        .wmask_i   (req_wmask),
        .mtime_o   (mtime),
        .mtimecmp_o(mtimecmp),
        .time_irq_o(time_irq)
    );

    assign req_ready      = (state_q == ST_IDLE);
    assign resp_valid     = (state_q == ST_RESP);
    assign resp_rdata     = rdata_q;
    assign resp_err       = err_q;
    assign time_interrupt = time_irq;
    assign soft_interrupt = msip_q;

endmodule

// File: tb/tb_ysyx_22051013_clint.sv
// Directed bench for the CLINT with TICK_DIV = 1: a table of bus accesses with
// hand-computed results, plus timed sequences for mtime, interrupts,
// back-pressure and reset during a response.
module tb_ysyx_22051013_clint;

    localparam logic [63:0] BASE  = 64'h0000_0000_0200_0000;
    localparam logic [63:0] A_MSIP = BASE + 64'h0000;
    localparam logic [63:0] A_CMP  = BASE + 64'h4000;
    localparam logic [63:0] A_TIME = BASE + 64'hBFF8;
    localparam logic [63:0] ONES   = 64'hFFFF_FFFF_FFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_wen;
    logic [63:0] req_addr, req_wdata;
    logic [7:0]  req_wmask;
    logic        resp_valid, resp_ready;
    logic [63:0] resp_rdata;
    logic        resp_err;
    logic        time_interrupt, soft_interrupt;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ysyx_22051013_clint #(
        .BASE_ADDR(BASE),
        .TICK_DIV (1)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_wen       (req_wen),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .req_wmask     (req_wmask),
        .resp_valid    (resp_valid),
        .resp_ready    (resp_ready),
        .resp_rdata    (resp_rdata),
        .resp_err      (resp_err),
        .time_interrupt(time_interrupt),
        .soft_interrupt(soft_interrupt)
    );

    typedef struct {
        logic        wen;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [7:0]  wmask;
        logic [63:0] exp_rdata;
        logic        exp_err;
        logic        exp_soft;
    } vec_t;

    localparam int NV = 22;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Start just after a clock edge with state IDLE; handshake lands on the next edge
    task automatic bus(input logic wen, input logic [63:0] addr, input logic [63:0] wdata,
                       input logic [7:0] wmask, output logic [63:0] rdata, output logic err);
        int t;
        t = 0;
        while (!req_ready && t < 20) begin
            @(posedge clk); #1;
            t++;
        end
        if (!req_ready) chk("req_ready_wait", {63'd0, req_ready}, 64'd1);
        req_valid = 1'b1;
        req_wen   = wen;
        req_addr  = addr;
        req_wdata = wdata;
        req_wmask = wmask;
        @(posedge clk); #1;
        req_valid = 1'b0;
        t = 0;
        while (!resp_valid && t < 20) begin
            @(posedge clk); #1;
            t++;
        end
        if (!resp_valid) chk("resp_valid_wait", {63'd0, resp_valid}, 64'd1);
        rdata = resp_rdata;
        err   = resp_err;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
    endtask

    // After this task mtime is 0 and the next edge is the first counting edge
    task automatic apply_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] rd;
        logic        er;

        vecs[0]  = '{1'b1, A_MSIP, 64'h1, 8'h01, 64'h0, 1'b0, 1'b1};
        vecs[1]  = '{1'b0, A_MSIP, 64'h0, 8'h00, 64'h1, 1'b0, 1'b1};
        vecs[2]  = '{1'b1, A_MSIP, 64'h0, 8'h00, 64'h0, 1'b0, 1'b1};
        vecs[3]  = '{1'b0, A_MSIP, 64'h0, 8'h00, 64'h1, 1'b0, 1'b1};
        vecs[4]  = '{1'b1, A_MSIP, 64'h0, 8'h01, 64'h0, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, A_MSIP, 64'hFFFF_FFFF_FFFF_FFFE, 8'hFF, 64'h0, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, A_MSIP, 64'h3, 8'h01, 64'h0, 1'b0, 1'b1};
        vecs[7]  = '{1'b0, A_MSIP, 64'h0, 8'h00, 64'h1, 1'b0, 1'b1};
        vecs[8]  = '{1'b1, A_MSIP, 64'h0, 8'h01, 64'h0, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, A_CMP,  64'h0, 8'hFF, 64'h0, 1'b0, 1'b0};
        vecs[10] = '{1'b1, A_CMP,  64'h1122_3344_5566_7788, 8'h0F, 64'h0, 1'b0, 1'b0};
        vecs[11] = '{1'b0, A_CMP,  64'h0, 8'h00, 64'h0000_0000_5566_7788, 1'b0, 1'b0};
        vecs[12] = '{1'b0, A_CMP + 64'h4, 64'h0, 8'h00, 64'h0000_0000_5566_7788, 1'b0, 1'b0};
        vecs[13] = '{1'b1, A_CMP,  64'hAAAA_BBBB_CCCC_DDDD, 8'hF0, 64'h0, 1'b0, 1'b0};
        vecs[14] = '{1'b0, A_CMP,  64'h0, 8'h00, 64'hAAAA_BBBB_5566_7788, 1'b0, 1'b0};
        vecs[15] = '{1'b0, BASE + 64'h1000, 64'h0, 8'h00, 64'h0, 1'b1, 1'b0};
        vecs[16] = '{1'b1, BASE + 64'h1000, ONES, 8'hFF, 64'h0, 1'b1, 1'b0};
        vecs[17] = '{1'b0, A_CMP,  64'h0, 8'h00, 64'hAAAA_BBBB_5566_7788, 1'b0, 1'b0};
        vecs[18] = '{1'b0, 64'h0000_0000_0300_0000, 64'h0, 8'h00, 64'h0, 1'b1, 1'b0};
        vecs[19] = '{1'b0, BASE + 64'h1_4000, 64'h0, 8'h00, 64'h0, 1'b1, 1'b0};
        vecs[20] = '{1'b1, A_CMP,  ONES, 8'hFF, 64'h0, 1'b0, 1'b0};
        vecs[21] = '{1'b0, A_CMP,  64'h0, 8'h00, ONES, 1'b0, 1'b0};

        rst = 1'b1; req_valid = 1'b0; req_wen = 1'b0; req_addr = '0;
        req_wdata = '0; req_wmask = '0; resp_ready = 1'b0;

        // Reset state
        apply_reset();
        chk("rst_req_ready",  {63'd0, req_ready},      64'd1);
        chk("rst_resp_valid", {63'd0, resp_valid},     64'd0);
        chk("rst_resp_rdata", resp_rdata,              64'd0);
        chk("rst_resp_err",   {63'd0, resp_err},       64'd0);
        chk("rst_time_irq",   {63'd0, time_interrupt}, 64'd0);
        chk("rst_soft_irq",   {63'd0, soft_interrupt}, 64'd0);

        // Ten idle edges, then the read handshake sees mtime = 10
        repeat (10) @(posedge clk);
        #1;
        chk("idle_time_irq", {63'd0, time_interrupt}, 64'd0);
        chk("idle_soft_irq", {63'd0, soft_interrupt}, 64'd0);
        bus(1'b0, A_TIME, 64'd0, 8'h00, rd, er);
        chk("idle_mtime", rd, 64'd10);
        chk("idle_mtime_err", {63'd0, er}, 64'd0);
        bus(1'b0, A_CMP, 64'd0, 8'h00, rd, er);
        chk("rst_mtimecmp", rd, ONES);

        // mtimecmp = 20 written at the edge where mtime goes 5 -> 6
        apply_reset();
        repeat (5) @(posedge clk);
        #1;
        bus(1'b1, A_CMP, 64'd20, 8'hFF, rd, er);
        repeat (13) @(posedge clk);
        #1;
        chk("irq_before_rise", {63'd0, time_interrupt}, 64'd0);
        @(posedge clk); #1;
        chk("irq_rise", {63'd0, time_interrupt}, 64'd1);
        bus(1'b1, A_CMP, ONES, 8'hFF, rd, er);
        chk("irq_fall", {63'd0, time_interrupt}, 64'd0);

        // mtime writes: empty mask, wrap, and write beating the same-edge tick
        apply_reset();
        bus(1'b1, A_TIME, ONES, 8'h00, rd, er);
        bus(1'b0, A_TIME, 64'd0, 8'h00, rd, er);
        chk("mtime_mask0_noop", rd, 64'd2);
        bus(1'b1, A_TIME, 64'hFFFF_FFFF_FFFF_FFFE, 8'hFF, rd, er);
        bus(1'b0, A_TIME, 64'd0, 8'h00, rd, er);
        chk("mtime_pre_wrap", rd, ONES);
        bus(1'b0, A_TIME, 64'd0, 8'h00, rd, er);
        chk("mtime_post_wrap", rd, 64'd1);
        // One tick elapses between the write edge and the read edge
        bus(1'b1, A_TIME, 64'h0000_0000_1234_5678, 8'hFF, rd, er);
        bus(1'b0, A_TIME, 64'd0, 8'h00, rd, er);
        chk("mtime_write_wins", rd, 64'h0000_0000_1234_5679);

        // Table of register accesses
        apply_reset();
        for (int i = 0; i < NV; i++) begin
            bus(vecs[i].wen, vecs[i].addr, vecs[i].wdata, vecs[i].wmask, rd, er);
            chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
            chk($sformatf("vec%0d_err", i), {63'd0, er}, {63'd0, vecs[i].exp_err});
            chk($sformatf("vec%0d_soft", i), {63'd0, soft_interrupt}, {63'd0, vecs[i].exp_soft});
        end

        // Back-pressure with a pending mtime read, then reset during RESP
        apply_reset();
        bus(1'b1, A_MSIP, 64'd1, 8'h01, rd, er);
        chk("bp_soft_set", {63'd0, soft_interrupt}, 64'd1);
        repeat (2) @(posedge clk);
        #1;
        req_valid = 1'b1; req_wen = 1'b0; req_addr = A_TIME; req_wmask = 8'h00;
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("bp%0d_resp_valid", c), {63'd0, resp_valid}, 64'd1);
            chk($sformatf("bp%0d_req_ready", c),  {63'd0, req_ready},  64'd0);
            chk($sformatf("bp%0d_rdata", c),      resp_rdata,          64'd4);
            chk($sformatf("bp%0d_err", c),        {63'd0, resp_err},   64'd0);
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rr_resp_valid", {63'd0, resp_valid},     64'd0);
        chk("rr_req_ready",  {63'd0, req_ready},      64'd1);
        chk("rr_resp_rdata", resp_rdata,              64'd0);
        chk("rr_soft_irq",   {63'd0, soft_interrupt}, 64'd0);
        bus(1'b0, A_TIME, 64'd0, 8'h00, rd, er);
        chk("rr_mtime", rd, 64'd0);
        bus(1'b0, A_MSIP, 64'd0, 8'h00, rd, er);
        chk("rr_msip", rd, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
